// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the LEGv8 fetch sequencer and its PC adder.
package fetch_sequencer_pkg;

    localparam int PC_W_DEF   = 64;
    localparam int INST_W_DEF = 32;
    localparam int CNT_W_DEF  = 32;

    localparam int PC_INC   = 4;
    localparam int BR_SHIFT = 2;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_FETCH,
        ST_EXEC,
        ST_HALT,
        ST_FAULT
    } state_t;

endpackage

// File: rtl/fetch_sequencer_pc_next_calc.sv
// Next-PC adder: sequential step or taken branch with word offset; wraps modulo 2^PC_W.
module pc_next_calc
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic [PC_W-1:0] currentpc,
    input  logic [PC_W-1:0] signextimm64,
    input  logic            branch,
    input  logic            aluzero,
    input  logic            uncondbranch,
    output logic [PC_W-1:0] next
);

    logic            take;
    logic [PC_W-1:0] offset;

    assign take = uncondbranch | (branch & aluzero);
    // Shifting within PC_W drops the immediate's top bits on purpose.
    assign offset = signextimm64 << BR_SHIFT;
    assign next = take ? (currentpc + offset) : (currentpc + PC_W'(PC_INC));

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/execute controller owning the PC: boot, fetch handshake, commit, halt, fault.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int INST_W = INST_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic [PC_W-1:0]   startpc,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] instruction,
    output logic [PC_W-1:0]   currentpc,
    input  logic              exec_done,
    input  logic              branch,
    input  logic              uncondbranch,
    input  logic              aluzero,
    input  logic [PC_W-1:0]   signextimm64,
    input  logic              halt_req,
    output logic              halted,
    output logic              fault,
    output logic [CNT_W-1:0]  retired
);

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_next;
    logic            fetch_hit, exec_hit;

    pc_next_calc #(.PC_W(PC_W)) u_pc_next (
        .currentpc   (currentpc),
        .signextimm64(signextimm64),
        .branch      (branch),
        .aluzero     (aluzero),
        .uncondbranch(uncondbranch),
        .next        (pc_next)
    );

    // Handshake outputs decode straight from state so reset drops them asynchronously.
    assign imem_req   = (state == ST_FETCH);
    assign inst_valid = (state == ST_EXEC);
    assign halted     = (state == ST_HALT);
    assign fault      = (state == ST_FAULT);
    assign imem_addr  = currentpc;

    assign fetch_hit = imem_req & imem_ack;
    assign exec_hit  = inst_valid & exec_done;

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) state <= ST_BOOT;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT:  state_nxt = (startpc[1:0] != 2'b00) ? ST_FAULT : ST_FETCH;
            ST_FETCH: if (imem_ack) state_nxt = ST_EXEC;
            ST_EXEC:  if (exec_done) state_nxt = halt_req ? ST_HALT : ST_FETCH;
            ST_HALT:  state_nxt = ST_HALT;
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            currentpc   <= '0;
            instruction <= '0;
            retired     <= '0;
        end else begin
            if (state == ST_BOOT) currentpc <= startpc;
            if (fetch_hit)        instruction <= imem_rdata;
            if (exec_hit) begin
                retired <= retired + CNT_W'(1);
                // A halting instruction retires but leaves the PC pointing at itself.
                if (!halt_req) currentpc <= pc_next;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: boot, wait states, branches, wrap, halt, fault, async reset.
module tb_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        resetl;
    logic [63:0] startpc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [63:0] currentpc;
    logic        exec_done, branch, uncondbranch, aluzero, halt_req;
    logic [63:0] signextimm64;
    logic        halted, fault;
    logic [31:0] retired;

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    fetch_sequencer dut (
        .CLK(CLK), .resetl(resetl), .startpc(startpc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst_valid(inst_valid), .instruction(instruction),
        .currentpc(currentpc), .exec_done(exec_done), .branch(branch),
        .uncondbranch(uncondbranch), .aluzero(aluzero), .signextimm64(signextimm64),
        .halt_req(halt_req), .halted(halted), .fault(fault), .retired(retired)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_inputs();
        imem_ack = 0; imem_rdata = '0; exec_done = 0; branch = 0;
        uncondbranch = 0; aluzero = 0; halt_req = 0; signextimm64 = '0;
    endtask

    // Reset, release, then clock through the single BOOT cycle.
    task automatic boot(input logic [63:0] sp);
        resetl = 0; clr_inputs(); startpc = sp;
        step();
        resetl = 1;
        step();
    endtask

    task automatic fetch(input int waits, input logic [63:0] pc, input logic [31:0] data);
        for (int i = 0; i < waits; i++) begin
            chk("wait_req", imem_req, 1);
            chk("wait_addr", imem_addr, pc);
            step();
        end
        chk("fetch_req", imem_req, 1);
        chk("fetch_addr", imem_addr, pc);
        imem_ack = 1; imem_rdata = data;
        step();
        imem_ack = 0;
        chk("inst_valid", inst_valid, 1);
        chk("instruction", instruction, {32'd0, data});
    endtask

    task automatic exec(input logic br, input logic ub, input logic az,
                        input logic [63:0] imm, input logic hr);
        branch = br; uncondbranch = ub; aluzero = az; signextimm64 = imm;
        halt_req = hr; exec_done = 1;
        step();
        clr_inputs();
    endtask

    initial begin
        resetl = 0; startpc = 64'h1000; clr_inputs();
        #12;
        chk("rst_req", imem_req, 0);
        chk("rst_ivalid", inst_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);
        chk("rst_pc", currentpc, 0);
        chk("rst_inst", instruction, 0);
        chk("rst_retired", retired, 0);

        // Boot with zero-wait fetch and immediate completion.
        boot(64'h1000);
        fetch(0, 64'h1000, 32'h0000_000A);
        exec(0, 0, 0, 64'h0, 0);
        chk("boot_pc", currentpc, 64'h1004);
        chk("boot_retired", retired, 1);
        chk("boot_refetch", imem_req, 1);

        // Three wait states; exec_done during FETCH must be ignored.
        exec_done = 1;
        step();
        exec_done = 0;
        chk("fetch_ign_done_pc", currentpc, 64'h1004);
        fetch(2, 64'h1004, 32'hCAFE_0001);
        // Spurious ack during EXEC.
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 0;
        chk("spur_ack_inst", instruction, 64'hCAFE_0001);
        chk("spur_ack_valid", inst_valid, 1);
        exec(0, 0, 0, 64'h0, 0);
        chk("seq2_pc", currentpc, 64'h1008);
        chk("seq2_retired", retired, 2);

        // Branch cases at 0x2000 with imm = -4.
        boot(64'h2000);
        fetch(0, 64'h2000, 32'h1);
        exec(1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        chk("br_nottaken", currentpc, 64'h2004);

        boot(64'h2000);
        fetch(0, 64'h2000, 32'h2);
        exec(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        chk("br_taken", currentpc, 64'h1FF0);

        boot(64'h2000);
        fetch(0, 64'h2000, 32'h3);
        exec(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        chk("uncond", currentpc, 64'h1FF0);

        // Immediate top bits discarded by the shift: 0xC..02 << 2 = 8.
        boot(64'h100);
        fetch(1, 64'h100, 32'h4);
        exec(0, 1, 0, 64'hC000_0000_0000_0002, 0);
        chk("imm_trunc", currentpc, 64'h108);

        // PC wraps to zero.
        boot(64'hFFFF_FFFF_FFFF_FFFC);
        fetch(0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h5);
        exec(0, 0, 0, 64'h0, 0);
        chk("wrap_pc", currentpc, 64'h0);
        chk("wrap_retired", retired, 1);

        // Halt.
        boot(64'h3000);
        fetch(0, 64'h3000, 32'h6);
        exec(1, 1, 1, 64'h10, 1);
        chk("halt_flag", halted, 1);
        chk("halt_pc", currentpc, 64'h3000);
        chk("halt_retired", retired, 1);
        imem_ack = 1; exec_done = 1;
        step(); step();
        clr_inputs();
        chk("halt_req_low", imem_req, 0);
        chk("halt_ivalid", inst_valid, 0);
        chk("halt_hold", halted, 1);
        chk("halt_pc_hold", currentpc, 64'h3000);

        // Misaligned start.
        boot(64'h1002);
        chk("fault_flag", fault, 1);
        chk("fault_req", imem_req, 0);
        step(); step();
        chk("fault_hold", fault, 1);
        chk("fault_req_hold", imem_req, 0);
        chk("fault_halted", halted, 0);

        // Async reset mid-FETCH, stale ack held through reset and BOOT.
        boot(64'h1000);
        chk("pre_rst_req", imem_req, 1);
        #3;
        resetl = 0; imem_ack = 1; imem_rdata = 32'hBAD0_BAD0; startpc = 64'h4000;
        #1;
        chk("async_req", imem_req, 0);
        chk("async_pc", currentpc, 0);
        @(posedge CLK); #1;
        resetl = 1;
        step();
        imem_ack = 0;
        chk("reboot_pc", currentpc, 64'h4000);
        chk("reboot_req", imem_req, 1);
        chk("reboot_inst", instruction, 0);
        fetch(0, 64'h4000, 32'h7);
        exec(0, 0, 0, 64'h0, 0);
        chk("reboot_next", currentpc, 64'h4004);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle fetch/execute controller that owns the program counter for the LEGv8 core. It fetches each instruction over a req/ack instruction-memory handshake and presents it to the datapath. It waits for the datapath to report completion with its branch flags, then computes and commits the next PC. It also handles boot from a start address, halt, and misaligned-start fault.

Parameters:
PC_W, 64, program counter and immediate width
INST_W, 32, instruction width
CNT_W, 32, retired-instruction counter width

Ports:
CLK  input  1  clock, rising edge
resetl  input  1  asynchronous active-low reset
startpc  input  PC_W  boot address, sampled in BOOT
imem_req  output  1  instruction fetch request
imem_addr  output  PC_W  fetch address, equals currentpc
imem_ack  input  1  fetch complete, imem_rdata valid
imem_rdata  input  INST_W  fetched instruction
inst_valid  output  1  instruction register valid to datapath
instruction  output  INST_W  instruction register
currentpc  output  PC_W  committed PC
exec_done  input  1  datapath finished current instruction
branch  input  1  conditional branch (CBZ class)
uncondbranch  input  1  unconditional branch
aluzero  input  1  ALU zero flag
signextimm64  input  PC_W  sign-extended word offset
halt_req  input  1  current instruction is halt
halted  output  1  sequencer stopped by halt
fault  output  1  sequencer stopped by misaligned startpc
retired  output  CNT_W  instructions completed, wraps at 2^CNT_W

Behaviour:
- Reset (resetl=0, async):
  - state=BOOT, currentpc=0, instruction=0, retired=0.
  - imem_req=0, inst_valid=0, halted=0, fault=0.
- States: BOOT, FETCH, EXEC, HALT, FAULT. Encoded and registered.
- BOOT: one cycle. currentpc<=startpc. If startpc[1:0]!=0, go to FAULT; else go to FETCH.
- FETCH:
  - imem_req=1, decoded from state. imem_addr=currentpc.
  - imem_ack is accepted in any FETCH cycle, including the first (zero-wait memory).
  - On ack: instruction<=imem_rdata, go to EXEC. Otherwise stay, holding req and addr stable.
- EXEC:
  - inst_valid=1, decoded from state.
  - exec_done is accepted in any EXEC cycle, including the first.
  - On exec_done with halt_req=1: go to HALT. currentpc is unchanged and retired increments.
  - On exec_done with halt_req=0:
    - currentpc<=next, retired<=retired+1, go to FETCH.
    - next = currentpc + (signextimm64<<2) when (uncondbranch | (branch & aluzero)); otherwise currentpc+4.
    - Arithmetic is modulo 2^PC_W.
- Minimum throughput: 2 cycles per instruction.
- HALT / FAULT: terminal until reset. halted=1 (HALT) or fault=1 (FAULT). imem_req=0, inst_valid=0. currentpc holds.
- Ignored inputs:
  - imem_ack outside FETCH.
  - exec_done, branch, uncondbranch, aluzero, signextimm64 and halt_req outside EXEC.
- Branch flags and halt_req are sampled only in the exec_done cycle.
- Boundaries:
  - pc+4 from 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
  - Negative offsets subtract correctly.
  - The immediate<<2 discards its top 2 bits.
  - uncondbranch=1 overrides aluzero and branch.
- Reset mid-FETCH or mid-EXEC drops imem_req and inst_valid immediately. A stale ack after reset is ignored.

Decomposition:
- Shared package holds:
  - state enum (BOOT, FETCH, EXEC, HALT, FAULT)
  - PC_INC=4 and BR_SHIFT=2
  - default widths.
- One combinational sub-module, pc_next_calc:
  - inputs: currentpc, signextimm64, branch, aluzero, uncondbranch
  - output: next
  - it is unit-tested separately.

Test Plan:
- Boot: startpc=0x1000, ack in the first FETCH cycle, exec_done with no branch -> imem_addr=0x1000, then currentpc=0x1004, retired=1.
- Wait states:
  - Ack 3 cycles after req -> req and addr stable throughout, instruction=imem_rdata.
  - Spurious ack during EXEC -> ignored.
- Branches at currentpc=0x2000, imm=-4 (0xFFFF_FFFF_FFFF_FFFC):
  - branch=1, aluzero=0 -> next 0x2004.
  - branch=1, aluzero=1 -> 0x1FF0.
  - uncondbranch=1, aluzero=0 -> 0x1FF0.
- Wrap: currentpc=0xFFFF_FFFF_FFFF_FFFC, no branch -> currentpc=0.
- Halt and fault:
  - exec_done with halt_req=1 at pc 0x3000 -> halted=1, currentpc=0x3000, imem_req stays 0.
  - startpc=0x1002 -> fault=1 after BOOT, no request issued.
- Async reset while imem_req=1 -> outputs 0 immediately, then a clean BOOT from the new startpc.
